// File: rtl/axil_mem_ctrl.sv
// axil_mem_ctrl: AXI-Lite slave memory with byte strobes, address range
// check, programmable read/write latency and runtime error injection.
//
// Ports:
//   clk, rst         clock (rising edge), synchronous active-high reset
//   err_mode         00/11 range check, 01 force OKAY, 10 force SLVERR
//   ar_* / r_*       read address / read data channels
//   aw_* / w_* / b_* write address / write data / write response channels
//
// Read and write paths are independent FSMs. Each commits (samples memory,
// err_mode and the address check) on the edge that enters its RESP state.
module axil_mem_ctrl #(
  parameter int ADDR_WDTH = 8,
  parameter int DATA_WDTH = 32,
  parameter int RESP_WDTH = 2,
  parameter int DEPTH     = 16,
  parameter int RD_LAT    = 1,
  parameter int WR_LAT    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             err_mode,
  input  logic                   ar_valid,
  output logic                   ar_ready,
  input  logic [ADDR_WDTH-1:0]   ar_address,
  output logic                   r_valid,
  input  logic                   r_ready,
  output logic [DATA_WDTH-1:0]   r_data,
  output logic [RESP_WDTH-1:0]   r_resp,
  input  logic                   aw_valid,
  output logic                   aw_ready,
  input  logic [ADDR_WDTH-1:0]   aw_address,
  input  logic                   w_valid,
  output logic                   w_ready,
  input  logic [DATA_WDTH-1:0]   w_data,
  input  logic [DATA_WDTH/8-1:0] w_strb,
  output logic                   b_valid,
  input  logic                   b_ready,
  output logic [RESP_WDTH-1:0]   b_resp
);

  localparam int unsigned BYTES = DATA_WDTH / 8;
  localparam int unsigned OFFS  = $clog2(BYTES);
  localparam int unsigned IW    = $clog2(DEPTH);
  localparam int unsigned RCW   = $clog2(RD_LAT + 1);
  localparam int unsigned WCW   = $clog2(WR_LAT + 1);

  localparam logic [RESP_WDTH-1:0] OKAY   = '0;
  localparam logic [RESP_WDTH-1:0] SLVERR = RESP_WDTH'(2);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;

  function automatic logic in_range(input logic [ADDR_WDTH-1:0] a);
    logic [ADDR_WDTH:0] idx;
    idx = {1'b0, a >> OFFS};
    return idx < (ADDR_WDTH+1)'(DEPTH);
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [ADDR_WDTH-1:0] a);
    return IW'(a >> OFFS);
  endfunction

  function automatic logic access_ok(input logic [1:0] mode, input logic inr);
    case (mode)
      2'b01:   return inr;
      2'b10:   return 1'b0;
      default: return inr;
    endcase
  endfunction

  function automatic logic [RESP_WDTH-1:0] resp_of(input logic [1:0] mode,
                                                   input logic inr);
    case (mode)
      2'b01:   return OKAY;
      2'b10:   return SLVERR;
      default: return inr ? OKAY : SLVERR;
    endcase
  endfunction

  logic [DATA_WDTH-1:0] r_mem [DEPTH];

  // ---------------- read path ----------------
  rd_state_t             r_rd_state;
  logic [RCW-1:0]        r_rd_cnt;
  logic [ADDR_WDTH-1:0]  r_ar_addr;

  logic                  w_rd_commit;
  logic [ADDR_WDTH-1:0]  w_rd_addr;
  logic                  w_rd_inr;
  logic [DATA_WDTH-1:0]  w_rd_data;
  logic [RESP_WDTH-1:0]  w_rd_resp;

  // With RD_LAT=1 the commit happens on the AR handshake edge itself,
  // so the live address is used instead of the latched one.
  assign w_rd_addr   = (r_rd_state == R_IDLE) ? ar_address : r_ar_addr;
  assign w_rd_inr    = in_range(w_rd_addr);
  assign w_rd_data   = access_ok(err_mode, w_rd_inr) ? r_mem[word_idx(w_rd_addr)] : '0;
  assign w_rd_resp   = resp_of(err_mode, w_rd_inr);
  assign w_rd_commit = ((r_rd_state == R_IDLE) && ar_valid && (RD_LAT == 1)) ||
                       ((r_rd_state == R_WAIT) && (r_rd_cnt == RCW'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_state <= R_IDLE;
      r_rd_cnt   <= '0;
      r_ar_addr  <= '0;
      ar_ready   <= 1'b1;
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_resp     <= '0;
    end else begin
      unique case (r_rd_state)
        R_IDLE: begin
          if (ar_valid) begin
            r_ar_addr <= ar_address;
            ar_ready  <= 1'b0;
            if (RD_LAT == 1) begin
              r_rd_state <= R_RESP;
            end else begin
              r_rd_cnt   <= RCW'(RD_LAT - 1);
              r_rd_state <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          if (r_rd_cnt == RCW'(1)) r_rd_state <= R_RESP;
          else                     r_rd_cnt   <= r_rd_cnt - 1'b1;
        end
        R_RESP: begin
          if (r_ready) begin
            r_valid    <= 1'b0;
            ar_ready   <= 1'b1;
            r_rd_state <= R_IDLE;
          end
        end
        default: r_rd_state <= R_IDLE;
      endcase
      if (w_rd_commit) begin
        r_data  <= w_rd_data;
        r_resp  <= w_rd_resp;
        r_valid <= 1'b1;
      end
    end
  end

  // ---------------- write path ----------------
  wr_state_t             r_wr_state;
  logic [WCW-1:0]        r_wr_cnt;
  logic [ADDR_WDTH-1:0]  r_aw_addr;
  logic [DATA_WDTH-1:0]  r_wdata;
  logic [BYTES-1:0]      r_wstrb;

  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_have_both;
  logic                  w_wr_commit;
  logic [ADDR_WDTH-1:0]  w_wr_addr;
  logic [DATA_WDTH-1:0]  w_wr_data;
  logic [BYTES-1:0]      w_wr_strb;
  logic                  w_wr_inr;
  logic                  w_wr_ok;
  logic [IW-1:0]         w_wr_idx;

  // Readies are only high in W_IDLE, so these handshakes imply W_IDLE.
  // A ready that is already low in W_IDLE means that channel is held.
  assign w_aw_hs     = aw_valid & aw_ready;
  assign w_w_hs      = w_valid & w_ready;
  assign w_have_both = (w_aw_hs | ~aw_ready) & (w_w_hs | ~w_ready);
  assign w_wr_addr   = w_aw_hs ? aw_address : r_aw_addr;
  assign w_wr_data   = w_w_hs  ? w_data     : r_wdata;
  assign w_wr_strb   = w_w_hs  ? w_strb     : r_wstrb;
  assign w_wr_inr    = in_range(w_wr_addr);
  assign w_wr_ok     = access_ok(err_mode, w_wr_inr);
  assign w_wr_idx    = word_idx(w_wr_addr);
  assign w_wr_commit = ((r_wr_state == W_IDLE) && w_have_both && (WR_LAT == 1)) ||
                       ((r_wr_state == W_WAIT) && (r_wr_cnt == WCW'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_state <= W_IDLE;
      r_wr_cnt   <= '0;
      r_aw_addr  <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      aw_ready   <= 1'b1;
      w_ready    <= 1'b1;
      b_valid    <= 1'b0;
      b_resp     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      unique case (r_wr_state)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_aw_addr <= aw_address;
            aw_ready  <= 1'b0;
          end
          if (w_w_hs) begin
            r_wdata <= w_data;
            r_wstrb <= w_strb;
            w_ready <= 1'b0;
          end
          if (w_have_both) begin
            if (WR_LAT == 1) begin
              r_wr_state <= W_RESP;
            end else begin
              r_wr_cnt   <= WCW'(WR_LAT - 1);
              r_wr_state <= W_WAIT;
            end
          end
        end
        W_WAIT: begin
          if (r_wr_cnt == WCW'(1)) r_wr_state <= W_RESP;
          else                     r_wr_cnt   <= r_wr_cnt - 1'b1;
        end
        W_RESP: begin
          if (b_ready) begin
            b_valid    <= 1'b0;
            aw_ready   <= 1'b1;
            w_ready    <= 1'b1;
            r_wr_state <= W_IDLE;
          end
        end
        default: r_wr_state <= W_IDLE;
      endcase
      if (w_wr_commit) begin
        if (w_wr_ok) begin
          for (int unsigned i = 0; i < BYTES; i++) begin
            if (w_wr_strb[i]) r_mem[w_wr_idx][8*i +: 8] <= w_wr_data[8*i +: 8];
          end
        end
        b_resp  <= resp_of(err_mode, w_wr_inr);
        b_valid <= 1'b1;
      end
    end
  end

endmodule
